// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
// mem_access_stage : pipeline memory stage, req/ack data bus with timeout
// Rev 1.0
// ============================================================================
module mem_access_stage #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] alu_result,
    input  logic        alu_zero,
    input  logic [4:0]  write_reg_addr,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        mem_reg,
    input  logic        reg_write,
    input  logic [31:0] mem_write_data,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        stall,
    output logic [31:0] read_data_buffered,
    output logic [31:0] alu_result_buffered,
    output logic [4:0]  write_reg_addr_buffered,
    output logic        mem_reg_buffered,
    output logic        reg_write_buffered,
    output logic        misaligned_buffered,
    output logic        bus_error_buffered
);

    localparam int                 c_CNT_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [c_CNT_W-1:0] r_cnt;
    logic               w_stall;
    logic               w_access;
    logic               w_aligned;
    logic               w_cnt_last;
    logic               w_unused;

    assign w_unused   = alu_zero;
    assign w_access   = mem_read | mem_write;
    assign w_aligned  = (alu_result[1:0] == 2'b00);
    assign w_cnt_last = (r_cnt == c_CNT_LAST);
    assign stall      = w_stall;

    always_comb begin
        w_state_next = r_state;
        w_stall      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_access && w_aligned) begin
                    w_stall      = 1'b1;
                    w_state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                // ack takes priority over the timeout abort
                if (dmem_ack || w_cnt_last) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_stall = 1'b1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == S_IDLE) begin
                if (w_access && w_aligned) begin
                    r_cnt      <= '0;
                    dmem_req   <= 1'b1;
                    dmem_we    <= mem_write;
                    dmem_addr  <= {alu_result[31:2], 2'b00};
                    dmem_wdata <= mem_write_data;
                end
            end else if (dmem_ack || w_cnt_last) begin
                dmem_req <= 1'b0;
            end else begin
                r_cnt <= r_cnt + c_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            read_data_buffered      <= '0;
            alu_result_buffered     <= '0;
            write_reg_addr_buffered <= '0;
            mem_reg_buffered        <= 1'b0;
            reg_write_buffered      <= 1'b0;
            misaligned_buffered     <= 1'b0;
            bus_error_buffered      <= 1'b0;
        end else if (w_stall) begin
            // bubble: suppress side effects, keep data fields
            mem_reg_buffered    <= 1'b0;
            reg_write_buffered  <= 1'b0;
            misaligned_buffered <= 1'b0;
            bus_error_buffered  <= 1'b0;
        end else begin
            alu_result_buffered     <= alu_result;
            write_reg_addr_buffered <= write_reg_addr;
            mem_reg_buffered        <= mem_reg;
            misaligned_buffered     <= 1'b0;
            bus_error_buffered      <= 1'b0;
            reg_write_buffered      <= reg_write;
            if (r_state == S_WAIT) begin
                if (dmem_ack) begin
                    if (!dmem_we) begin
                        read_data_buffered <= dmem_rdata;
                    end
                end else begin
                    reg_write_buffered <= 1'b0;
                    bus_error_buffered <= 1'b1;
                end
            end else if (w_access) begin
                // only a misaligned access reaches here without stalling
                reg_write_buffered  <= 1'b0;
                misaligned_buffered <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// ============================================================================
// tb_mem_access_stage : randomized self-checking bench with transaction model
// Rev 1.0
// ============================================================================
module tb_mem_access_stage;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] alu_result = '0;
    logic        alu_zero = 1'b0;
    logic [4:0]  write_reg_addr = '0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic        mem_reg = 1'b0;
    logic        reg_write = 1'b0;
    logic [31:0] mem_write_data = '0;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata = '0;
    logic        dmem_ack = 1'b0;
    logic        stall;
    logic [31:0] read_data_buffered;
    logic [31:0] alu_result_buffered;
    logic [4:0]  write_reg_addr_buffered;
    logic        mem_reg_buffered;
    logic        reg_write_buffered;
    logic        misaligned_buffered;
    logic        bus_error_buffered;

    int total = 0;
    int bad   = 0;

    // expected architectural MW state carried between transactions
    logic [31:0] m_rdata;
    logic [31:0] m_alu;
    logic        m_alu_known;

    mem_access_stage #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .write_reg_addr(write_reg_addr),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_reg(mem_reg), .reg_write(reg_write),
        .mem_write_data(mem_write_data),
        .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .stall(stall),
        .read_data_buffered(read_data_buffered),
        .alu_result_buffered(alu_result_buffered),
        .write_reg_addr_buffered(write_reg_addr_buffered),
        .mem_reg_buffered(mem_reg_buffered),
        .reg_write_buffered(reg_write_buffered),
        .misaligned_buffered(misaligned_buffered),
        .bus_error_buffered(bus_error_buffered)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req"},   dmem_req, 0);
        check({tag, "_we"},    dmem_we, 0);
        check({tag, "_addr"},  dmem_addr, 0);
        check({tag, "_wdata"}, dmem_wdata, 0);
        check({tag, "_rdb"},   read_data_buffered, 0);
        check({tag, "_alub"},  alu_result_buffered, 0);
        check({tag, "_wrab"},  write_reg_addr_buffered, 0);
        check({tag, "_mrb"},   mem_reg_buffered, 0);
        check({tag, "_rwb"},   reg_write_buffered, 0);
        check({tag, "_misb"},  misaligned_buffered, 0);
        check({tag, "_berb"},  bus_error_buffered, 0);
    endtask

    // One instruction through the stage. k = WAIT cycle (1-based) in which the
    // bench memory acks; k > TO means it never acks. idle_ack pulses ack in cycle 0.
    task automatic run_op(input logic rd, input logic wr, input logic rw, input logic mr,
                          input logic [4:0] wra, input logic [31:0] addr,
                          input logic [31:0] wdata, input int k,
                          input logic [31:0] rdat, input logic idle_ack);
        logic        acc;
        logic        algn;
        logic        tmo;
        int          d;
        logic [31:0] rd_now;
        acc  = rd | wr;
        algn = (addr[1:0] == 2'b00);
        tmo  = 1'b0;
        d    = 0;
        rd_now = '0;
        if (acc && algn) begin
            d   = (k <= TO) ? k : TO;
            tmo = (k > TO);
        end
        for (int c = 0; c <= d; c++) begin
            @(negedge clk);
            mem_read       = rd;
            mem_write      = wr;
            reg_write      = rw;
            mem_reg        = mr;
            write_reg_addr = wra;
            alu_result     = addr;
            mem_write_data = wdata;
            alu_zero       = $urandom_range(0, 1);
            dmem_ack       = (c == 0) ? idle_ack : (c == k);
            dmem_rdata     = (c == k) ? rdat : $urandom;
            rd_now         = dmem_rdata;
            #1;
            check("stall", stall, (c < d));
            check("req", dmem_req, (c >= 1));
            if (c >= 1) begin
                check("addr", dmem_addr, {addr[31:2], 2'b00});
                check("we", dmem_we, wr);
                if (wr) check("wdata", dmem_wdata, wdata);
            end
            @(posedge clk);
            #1;
            if (c < d) begin
                check("bub_rw", reg_write_buffered, 0);
                check("bub_mr", mem_reg_buffered, 0);
                check("bub_mis", misaligned_buffered, 0);
                check("bub_berr", bus_error_buffered, 0);
                check("bub_rd", read_data_buffered, m_rdata);
                if (m_alu_known) check("bub_alu", alu_result_buffered, m_alu);
            end else if (tmo) begin
                check("to_rw", reg_write_buffered, 0);
                check("to_berr", bus_error_buffered, 1);
                check("to_mis", misaligned_buffered, 0);
                check("to_rd", read_data_buffered, m_rdata);
                m_alu_known = 1'b0;
            end else begin
                if (acc && algn && !wr) m_rdata = rd_now;
                m_alu       = addr;
                m_alu_known = 1'b1;
                check("mw_alu", alu_result_buffered, addr);
                check("mw_wra", write_reg_addr_buffered, wra);
                check("mw_mr", mem_reg_buffered, mr);
                check("mw_rw", reg_write_buffered, (acc && !algn) ? 1'b0 : rw);
                check("mw_mis", misaligned_buffered, acc && !algn);
                check("mw_berr", bus_error_buffered, 0);
                check("mw_rd", read_data_buffered, m_rdata);
            end
        end
    endtask

    initial begin
        m_rdata     = '0;
        m_alu       = '0;
        m_alu_known = 1'b1;
        #1;
        check_all_zero("rst0");
        check("rst0_stall", stall, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        // directed scenarios
        run_op(0, 0, 1, 0, 5'd5, 32'h1234, 32'h0, 0, 32'h0, 1'b1);
        run_op(1, 0, 1, 1, 5'd7, 32'h100, 32'h0, 3, 32'hDEADBEEF, 1'b0);
        run_op(0, 1, 0, 0, 5'd0, 32'h200, 32'hA5A5A5A5, 1, 32'h0, 1'b0);
        run_op(1, 0, 1, 1, 5'd9, 32'h103, 32'h0, 1, 32'h0, 1'b0);
        run_op(1, 0, 1, 1, 5'd3, 32'h300, 32'h0, TO + 1, 32'h0, 1'b0);
        run_op(1, 0, 1, 1, 5'd3, 32'h300, 32'h0, TO, 32'h13579BDF, 1'b0);
        run_op(1, 1, 1, 0, 5'd4, 32'h400, 32'h0BADF00D, 2, 32'h77777777, 1'b0);

        // reset in the second WAIT cycle
        @(negedge clk);
        mem_read = 1'b1; mem_write = 1'b0; reg_write = 1'b1; mem_reg = 1'b1;
        alu_result = 32'h500; write_reg_addr = 5'd11; dmem_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_all_zero("rstw");
        @(posedge clk);
        #1;
        check("rstw_hold_req", dmem_req, 0);
        @(negedge clk);
        mem_read = 1'b0; mem_write = 1'b0; reg_write = 1'b0; mem_reg = 1'b0;
        rst = 1'b1;
        m_rdata     = '0;
        m_alu       = '0;
        m_alu_known = 1'b1;
        run_op(0, 0, 1, 0, 5'd6, 32'hCAFE0000, 32'h0, 0, 32'h0, 1'b0);

        // randomized traffic
        for (int n = 0; n < 150; n++) begin
            int          sel;
            logic [31:0] a;
            sel = $urandom_range(0, 3);
            a   = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            run_op(sel == 1 || sel == 3, sel == 2 || sel == 3,
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   5'($urandom_range(0, 31)), a, $urandom,
                   $urandom_range(1, TO + 1), $urandom, 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
